ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), to the keyboard over the same open-drain PS2_CLK/PS2_DATA pair that the scan-code receiver listens on. The block does the following, in order:
- runs the request-to-send sequence;
- shifts out data, odd parity and stop bits on device-generated clock edges;
- checks the device ACK.

TX_BUSY gates the receiver so the receiver ignores device clocks during a host frame.

---
 rtl/ps2_host_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11 device-clocked bits, ACK check.
// Optional build macro PS2_TX_RETRY_EN: one silent retry before a failure is reported.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_err,
    output logic [1:0] o_err_code,
    output logic [2:0] o_dbg_state
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQUEST   = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [WD_W-1:0]  r_wdog, w_wdog;
    logic [3:0]       r_idx, w_idx;
    logic [9:0]       r_frame, w_frame;
    logic             r_clk_oe, w_clk_oe;
    logic             r_data_oe, w_data_oe;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_err, w_err;
    logic [1:0]       r_err_code, w_err_code;
    logic             w_fail;
    logic [1:0]       w_fail_code;
    logic             r_clk_s1, r_clk_s2, r_clk_prev;
    logic             r_dat_s1, r_dat_s2;
    logic             w_fe;
`ifdef PS2_TX_RETRY_EN
    logic             r_retried, w_retried;
`endif

    // Synchronizers reset to 1 (idle bus) so release of reset never fakes a falling edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fe = r_clk_prev & ~r_clk_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wdog     <= '0;
            r_idx      <= '0;
            r_frame    <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            r_retried  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_wdog     <= w_wdog;
            r_idx      <= w_idx;
            r_frame    <= w_frame;
            r_clk_oe   <= w_clk_oe;
            r_data_oe  <= w_data_oe;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_err_code <= w_err_code;
`ifdef PS2_TX_RETRY_EN
            r_retried  <= w_retried;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_wdog      = r_wdog;
        w_idx       = r_idx;
        w_frame     = r_frame;
        w_clk_oe    = r_clk_oe;
        w_data_oe   = r_data_oe;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_err_code  = r_err_code;
        w_fail      = 1'b0;
        w_fail_code = 2'b00;
`ifdef PS2_TX_RETRY_EN
        w_retried   = r_retried;
`endif
        case (r_state)
            S_IDLE: begin
                w_clk_oe  = 1'b0;
                w_data_oe = 1'b0;
                w_busy    = 1'b0;
                // A start coinciding with the previous frame's DONE/ERR pulse is dropped.
                if (i_tx_start && !r_done && !r_err) begin
                    w_state    = S_INHIBIT;
                    w_frame    = {1'b1, ~^i_tx_data, i_tx_data};
                    w_cnt      = '0;
                    w_clk_oe   = 1'b1;
                    w_busy     = 1'b1;
                    w_err_code = 2'b00;
`ifdef PS2_TX_RETRY_EN
                    w_retried  = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_state   = S_REQUEST;
                    w_cnt     = '0;
                    w_data_oe = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_REQUEST: begin
                if (r_cnt == SET_LAST) begin
                    w_state  = S_SEND;
                    w_clk_oe = 1'b0;
                    w_idx    = '0;
                    w_wdog   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_SEND: begin
                if (w_fe) begin
                    w_wdog = '0;
                    w_idx  = r_idx + 1'b1;
                    if (r_idx == 4'd10) begin
                        if (!r_dat_s2) begin
                            w_state = S_WAIT_IDLE;
                        end else begin
                            w_fail      = 1'b1;
                            w_fail_code = 2'b10;
                        end
                    end else begin
                        // Frame bit 9 is the stop bit (1), so the line is released there.
                        w_data_oe = ~r_frame[r_idx];
                    end
                end else if (r_wdog == WD_LAST) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'b01;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_s2 && r_dat_s2) begin
                    w_state = S_IDLE;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                end else if (w_fe) begin
                    w_wdog = '0;
                end else if (r_wdog == WD_LAST) begin
                    w_fail      = 1'b1;
                    w_fail_code = 2'b01;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase

        if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!r_retried) begin
                w_retried = 1'b1;
                w_state   = S_INHIBIT;
                w_cnt     = '0;
                w_clk_oe  = 1'b1;
                w_data_oe = 1'b0;
            end else begin
                w_state    = S_IDLE;
                w_clk_oe   = 1'b0;
                w_data_oe  = 1'b0;
                w_busy     = 1'b0;
                w_err      = 1'b1;
                w_err_code = w_fail_code;
            end
`else
            w_state    = S_IDLE;
            w_clk_oe   = 1'b0;
            w_data_oe  = 1'b0;
            w_busy     = 1'b0;
            w_err      = 1'b1;
            w_err_code = w_fail_code;
`endif
        end
    end

    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign o_tx_busy     = r_busy;
    assign o_tx_done     = r_done;
    assign o_tx_err      = r_err;
    assign o_err_code    = r_err_code;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int SET  = 5;
    localparam int TMO  = 200;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;
    logic       clk_oe, data_oe, busy, done, err;
    logic [1:0] err_code;
    logic [2:0] dbg_state;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_done = 0;
    int         n_err = 0;
    logic [1:0] code_at_err = 2'b00;
    logic       busy_at_err = 1'b0;

    logic [9:0] bits;
    int         hi, d_at, cyc;

    assign ps2_clk  = dev_clk & ~clk_oe;
    assign ps2_data = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tx_data    (tx_data),
        .i_tx_start   (tx_start),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe),
        .o_tx_busy    (busy),
        .o_tx_done    (done),
        .o_tx_err     (err),
        .o_err_code   (err_code),
        .o_dbg_state  (dbg_state)
    );

    // Pulse monitor; its counters are read only one or more cycles after a pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            if (err) begin
                n_err++;
                code_at_err = err_code;
                busy_at_err = busy;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic measure_req(output int n_hi, output int n_d);
        n_hi = 0;
        n_d  = -1;
        while (clk_oe === 1'b1 && n_hi < 1000) begin
            if (data_oe === 1'b1 && n_d < 0) n_d = n_hi;
            n_hi++;
            @(negedge clk);
        end
    endtask

    task automatic dev_frame(input logic ack, input int nclk, output logic [9:0] got);
        got = '0;
        tick(10);
        for (int i = 0; i < nclk; i++) begin
            if (i == 10 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            tick(HALF);
            if (i < 10) got[i] = ps2_data;
            dev_clk = 1'b1;
            tick(HALF);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (done !== 1'b1 && err !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick(2);

        // 0xED with ACK; start on the DONE cycle must be ignored
        start_tx(8'hED);
        chk("ed_busy", busy, 1);
        chk("ed_clk_oe", clk_oe, 1);
        chk("ed_data_oe0", data_oe, 0);
        measure_req(hi, d_at);
        chk("ed_clk_oe_len", hi, 25);
        chk("ed_data_oe_at", d_at, 20);
        chk("ed_start_bit", data_oe, 1);
        dev_frame(1'b1, 11, bits);
        chk("ed_bits", bits, 10'h3ED);
        wait_end(cyc);
        chk("ed_done", done, 1);
        chk("ed_no_err", err, 0);
        chk("ed_busy_fall", busy, 0);
        chk("ed_err_code", err_code, 0);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("ed_done_pulse", done, 0);
        chk("ed_start_on_done_busy", busy, 0);
        chk("ed_start_on_done_oe", clk_oe, 0);
        tick(2);
        chk("ed_n_done", n_done, 1);
        chk("ed_n_err", n_err, 0);

        // 0xF4: parity 0
        start_tx(8'hF4);
        measure_req(hi, d_at);
        dev_frame(1'b1, 11, bits);
        chk("f4_bits", bits, 10'h2F4);
        chk("f4_parity", bits[8], 0);
        wait_end(cyc);
        chk("f4_done", done, 1);
        tick(2);
        chk("f4_n_done", n_done, 2);

        // No ACK from the device
        start_tx(8'hED);
        measure_req(hi, d_at);
        dev_frame(1'b0, 11, bits);
        tick(1);
        chk("nack_n_err", n_err, 1);
        chk("nack_code_at_err", code_at_err, 2'b10);
        chk("nack_busy_at_err", busy_at_err, 0);
        chk("nack_clk_oe", clk_oe, 0);
        chk("nack_data_oe", data_oe, 0);
        chk("nack_busy", busy, 0);
        chk("nack_code_held", err_code, 2'b10);
        chk("nack_n_done", n_done, 2);

        // Device never clocks: watchdog
        start_tx(8'hED);
        chk("tmo_code_cleared", err_code, 0);
        measure_req(hi, d_at);
        wait_end(cyc);
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 2'b01);
        chk("tmo_busy", busy, 0);
        chk("tmo_clk_oe", clk_oe, 0);
        chk("tmo_data_oe", data_oe, 0);
        tick(2);
        chk("tmo_n_err", n_err, 2);

        // Start while busy is ignored
        start_tx(8'hED);
        measure_req(hi, d_at);
        fork
            dev_frame(1'b1, 11, bits);
            begin
                tick(100);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
            end
        join
        chk("busy_start_bits", bits, 10'h3ED);
        wait_end(cyc);
        chk("busy_start_done", done, 1);
        tick(2);
        chk("busy_start_n_done", n_done, 3);
        chk("busy_start_idle", busy, 0);
        chk("busy_start_clk_oe", clk_oe, 0);

        // Reset at idx 4, then a clean 0xF4
        start_tx(8'hED);
        measure_req(hi, d_at);
        dev_frame(1'b1, 4, bits);
        dev_clk = 1'b0;
        tick(5);
        chk("mid_data_oe", data_oe, 1);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data_oe", data_oe, 0);
        chk("arst_clk_oe", clk_oe, 0);
        chk("arst_busy", busy, 0);
        chk("arst_state", dbg_state, 0);
        dev_clk = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("arst_no_err", n_err, 2);
        chk("arst_code", err_code, 0);
        start_tx(8'hF4);
        measure_req(hi, d_at);
        chk("post_rst_clk_oe_len", hi, 25);
        dev_frame(1'b1, 11, bits);
        chk("post_rst_bits", bits, 10'h2F4);
        wait_end(cyc);
        chk("post_rst_done", done, 1);
        tick(2);
        chk("post_rst_n_done", n_done, 4);
        chk("post_rst_n_err", n_err, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
